noc_output_arbiter: RTL and testbench
=====================================

NOC_OUTPUT_ARBITER -- requirements
Module: noc_output_arbiter

Interface
REQ-001 SHALL have parameter FLIT_W, default 64, flit payload width in bits.
REQ-002 SHALL have parameter NUM_IN, default 5, number of requesting input ports (N/E/S/W/local).
REQ-003 SHALL have parameter CREDITS, default 4, downstream buffer depth (equals Noc_VC_Fifo_Depth).
REQ-004 SHALL have port noc_clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port noc_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  in  NUM_IN  per-input flit valid from route-selector outputs.
REQ-007 SHALL have port in_flit  in  NUM_IN*FLIT_W  per-input flit; input i at bits [i*FLIT_W +: FLIT_W].
REQ-008 SHALL have port in_tail  in  NUM_IN  per-input tail marker; a head flit with tail set is a single-flit packet.
REQ-009 SHALL have port in_ready  out  NUM_IN  per-input accept, combinational.
REQ-010 SHALL have port out_valid  out  1  registered flit valid to link.
REQ-011 SHALL have port out_flit  out  FLIT_W  registered flit.
REQ-012 SHALL have port out_tail  out  1  registered tail marker.
REQ-013 SHALL have port credit_in  in  1  one-cycle pulse: downstream freed one slot.
REQ-014 SHALL have port owner  out  3  index of input currently holding the output; 0 when IDLE.
REQ-015 SHALL have port credit_err  out  1  sticky overflow flag.

Function
REQ-016 Transfer on input i SHALL occur in a cycle where in_valid[i] && in_ready[i].
REQ-017 FSM SHALL have states IDLE and LOCKED.
REQ-018 In IDLE with credits>0, SHALL grant one requester by round-robin, searching from rr_ptr+1 upward modulo NUM_IN; in_ready asserted only for the winner, same cycle.
REQ-019 In IDLE with credits==0, all in_ready SHALL be 0.
REQ-020 IDLE grant with in_tail=0 SHALL move to LOCKED with owner=winner; with in_tail=1, SHALL stay IDLE.
REQ-021 On every IDLE grant, rr_ptr SHALL be updated to the winner index.
REQ-022 In LOCKED, in_ready[owner] SHALL equal (credits>0), and all other in_ready SHALL be 0 (wormhole lock).
REQ-023 A LOCKED transfer with in_tail=1 SHALL return the FSM to IDLE the next cycle.
REQ-024 Each transferred flit SHALL appear on out_flit/out_tail with out_valid=1 exactly one cycle later; otherwise out_valid SHALL be 0 and out_flit SHALL hold its value.
REQ-025 Credit counter (width clog2(CREDITS+1)) SHALL decrement on transfer and increment on credit_in; on simultaneous transfer and credit_in it SHALL remain unchanged.
REQ-026 credit_in when the counter equals CREDITS with no transfer SHALL be ignored and SHALL set credit_err until reset.
REQ-027 in_valid on a non-owner while LOCKED SHALL be held off without loss; the arbiter SHALL NOT reorder or drop flits.

Reset
REQ-028 While noc_rst=1 at a clock edge: FSM=IDLE, rr_ptr=NUM_IN-1, credits=CREDITS, out_valid=0, out_flit=0, out_tail=0, owner=0, credit_err=0.
REQ-029 in_ready SHALL be all-zero while noc_rst=1.
REQ-030 Reset asserted mid-packet SHALL abandon the lock; the partial packet is not resumed.

Configuration
REQ-031 With macro NOC_OUTPUT_ARB_PERF_EN defined, SHALL add outputs flit_cnt (16) and stall_cnt (16).
REQ-032 flit_cnt SHALL count transfers; stall_cnt SHALL count cycles with any in_valid and credits==0; both SHALL saturate at 16'hFFFF and reset to 0.
REQ-033 Without NOC_OUTPUT_ARB_PERF_EN, these ports and counters SHALL NOT exist, with no other behaviour change.

Verification
REQ-034 After reset, in_valid=5'b00101 with single-flit packets every cycle -> grants alternate 0,2,0,2; out_valid follows one cycle after each grant.
REQ-035 Input 1 sends 3-flit packet (tail on 3rd) while input 3 valid -> input 1 gets 3 consecutive transfers, then input 3 granted; out_tail high only on the 3rd output flit.
REQ-036 CREDITS=4, no credit_in, input 0 sends 6 flits -> 4 transfers, in_ready[0]=0 afterwards; one credit_in pulse -> exactly one more transfer.
REQ-037 Transfer and credit_in in the same cycle with credits=1 -> credits stay 1, in_ready remains 1.
REQ-038 Counter at CREDITS, credit_in pulsed -> credit_err=1 and stays 1 until noc_rst.
REQ-039 noc_rst asserted in LOCKED after 2 flits of a 4-flit packet -> next cycle IDLE, out_valid=0, credits=CREDITS, owner=0.

Source files
------------

// File: rtl/noc_output_arbiter.sv
// Wormhole output arbiter: round-robin grant, per-packet lock, credit-gated link. Optional perf counters: NOC_OUTPUT_ARB_PERF_EN.
// Latency: in_ready is combinational; a transferred flit reaches out_* on the following cycle.
// Backpressure: in_ready is low when no downstream credit is left, and for every non-owner while a packet is locked.
module noc_output_arbiter #(
    parameter int FLIT_W  = 64,
    parameter int NUM_IN  = 5,
    parameter int CREDITS = 4
) (
    input  logic                     noc_clk,
    input  logic                     noc_rst,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*FLIT_W-1:0] in_flit,
    input  logic [NUM_IN-1:0]        in_tail,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [FLIT_W-1:0]        out_flit,
    output logic                     out_tail,
    input  logic                     credit_in,
    output logic [2:0]               owner,
    output logic                     credit_err
`ifdef NOC_OUTPUT_ARB_PERF_EN
    ,
    output logic [15:0]              flit_cnt,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int CW  = $clog2(CREDITS + 1);
    localparam int RRW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);
    localparam logic [RRW-1:0] RR_INIT  = RRW'(NUM_IN - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state_q, state_d;
    logic [RRW-1:0] rr_ptr_q;
    logic [RRW-1:0] owner_q;
    logic [RRW-1:0] win_idx;
    logic [RRW-1:0] sel_idx;
    logic [RRW-1:0] cand;
    logic           win_found;
    logic [CW-1:0]  credits_q;
    logic           cred_ok;
    logic           xfer;

    assign cred_ok = (credits_q != '0);
    assign xfer    = |(in_valid & in_ready);
    assign sel_idx = (state_q == LOCKED) ? owner_q : win_idx;

    // Round-robin search starts just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = RRW'((int'(rr_ptr_q) + k) % NUM_IN);
            if (!win_found && in_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer && !in_tail[win_idx]) state_d = LOCKED;
            LOCKED:  if (xfer && in_tail[owner_q])  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = '0;
        owner    = 3'd0;
        if (!noc_rst) begin
            case (state_q)
                IDLE:    if (cred_ok && win_found) in_ready[win_idx] = 1'b1;
                LOCKED:  in_ready[owner_q] = cred_ok;
                default: ;
            endcase
        end
        if (state_q == LOCKED) owner = 3'(owner_q);
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            rr_ptr_q <= RR_INIT;
            owner_q  <= '0;
        end else if (state_q == IDLE && xfer) begin
            rr_ptr_q <= win_idx;
            if (!in_tail[win_idx]) owner_q <= win_idx;
        end
    end

    // A surplus credit is dropped rather than wrapping the counter.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            credits_q  <= CRED_MAX;
            credit_err <= 1'b0;
        end else begin
            case ({xfer, credit_in})
                2'b10: credits_q <= credits_q - CW'(1);
                2'b01: begin
                    if (credits_q == CRED_MAX) credit_err <= 1'b1;
                    else                       credits_q  <= credits_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_tail  <= 1'b0;
        end else begin
            out_valid <= xfer;
            if (xfer) begin
                out_flit <= in_flit[int'(sel_idx)*FLIT_W +: FLIT_W];
                out_tail <= in_tail[sel_idx];
            end
        end
    end

`ifdef NOC_OUTPUT_ARB_PERF_EN
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            flit_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (xfer && flit_cnt != 16'hFFFF)
                flit_cnt <= flit_cnt + 16'd1;
            if ((|in_valid) && !cred_ok && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: per-scenario tasks, expected flits queued at grant and popped at link output.
module tb_noc_output_arbiter;

    localparam int FW = 64;
    localparam int N  = 5;

    logic            noc_clk = 1'b0;
    logic            noc_rst = 1'b1;
    logic [N-1:0]    in_valid = '0;
    logic [N*FW-1:0] in_flit = '0;
    logic [N-1:0]    in_tail = '0;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [FW-1:0]   out_flit;
    logic            out_tail;
    logic            credit_in = 1'b0;
    logic [2:0]      owner;
    logic            credit_err;
`ifdef NOC_OUTPUT_ARB_PERF_EN
    logic [15:0]     flit_cnt;
    logic [15:0]     stall_cnt;
`endif

    typedef struct packed {
        logic [FW-1:0] flit;
        logic          tail;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            seq = 0;
    logic [FW-1:0] last_flit = '0;

    noc_output_arbiter #(.FLIT_W(FW), .NUM_IN(N), .CREDITS(4)) dut (
        .noc_clk    (noc_clk),
        .noc_rst    (noc_rst),
        .in_valid   (in_valid),
        .in_flit    (in_flit),
        .in_tail    (in_tail),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_flit   (out_flit),
        .out_tail   (out_tail),
        .credit_in  (credit_in),
        .owner      (owner),
        .credit_err (credit_err)
`ifdef NOC_OUTPUT_ARB_PERF_EN
        ,
        .flit_cnt   (flit_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial forever #5 noc_clk = ~noc_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus: drive, check in_ready, queue the expected flit, then check the link output.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] t, input logic cr,
                         input logic [N-1:0] exp_rdy, input string nm);
        logic [N-1:0] x;
        exp_t e;
        @(negedge noc_clk);
        in_valid  = v;
        in_tail   = t;
        credit_in = cr;
        for (int i = 0; i < N; i++) in_flit[i*FW +: FW] = {32'(i + 1), 32'(seq)};
        seq++;
        #1;
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s in_ready got=%b exp=%b", nm, in_ready, exp_rdy);
        end
        x = exp_rdy & v;
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                e.flit = in_flit[i*FW +: FW];
                e.tail = t[i];
                sb.push_back(e);
            end
        end
        @(posedge noc_clk);
        #1;
        in_valid  = '0;
        credit_in = 1'b0;
        checks++;
        if (out_valid !== (|x)) begin
            errors++;
            $display("FAIL %s out_valid got=%b exp=%b", nm, out_valid, |x);
        end
        if (out_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({out_flit, out_tail} !== {e.flit, e.tail}) begin
                errors++;
                $display("FAIL %s out flit/tail got=%h/%b exp=%h/%b", nm, out_flit, out_tail, e.flit, e.tail);
            end
            last_flit = e.flit;
        end else if (!(|x)) begin
            checks++;
            if (out_flit !== last_flit) begin
                errors++;
                $display("FAIL %s out_flit hold got=%h exp=%h", nm, out_flit, last_flit);
            end
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge noc_clk);
        noc_rst   = 1'b1;
        in_valid  = '1;
        in_tail   = '1;
        credit_in = 1'b0;
        #1;
        checks++;
        if (in_ready !== '0) begin
            errors++;
            $display("FAIL %s in_ready during reset got=%b exp=0", nm, in_ready);
        end
        @(posedge noc_clk);
        #1;
        checks++;
        if ({out_valid, out_flit, out_tail, owner, credit_err} !== '0) begin
            errors++;
            $display("FAIL %s reset state got ov=%b flit=%h tail=%b owner=%0d err=%b exp all 0",
                     nm, out_valid, out_flit, out_tail, owner, credit_err);
        end
        @(negedge noc_clk);
        noc_rst  = 1'b0;
        in_valid = '0;
        in_tail  = '0;
        sb.delete();
        last_flit = '0;
    endtask

    task automatic check_owner(input logic [2:0] exp, input string nm);
        checks++;
        if (owner !== exp) begin
            errors++;
            $display("FAIL %s owner got=%0d exp=%0d", nm, owner, exp);
        end
    endtask

    task automatic check_err(input logic exp, input string nm);
        checks++;
        if (credit_err !== exp) begin
            errors++;
            $display("FAIL %s credit_err got=%b exp=%b", nm, credit_err, exp);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
        check_owner(3'd0, "reset_owner");
        check_err(1'b0, "reset_err");
    endtask

    task automatic test_rr_alternate();
        int g[4] = '{0, 2, 0, 2};
        do_reset("rr_reset");
        for (int k = 0; k < 4; k++) begin
            cycle(5'b00101, 5'b11111, 1'b1, 5'(1) << g[k], "rr_alternate");
            check_owner(3'd0, "rr_owner_idle");
        end
    endtask

    task automatic test_wormhole();
        cycle(5'b00010, 5'b00000, 1'b1, 5'b00010, "worm_head");
        check_owner(3'd1, "worm_owner_locked");
        cycle(5'b01010, 5'b01000, 1'b1, 5'b00010, "worm_body");
        check_owner(3'd1, "worm_owner_body");
        cycle(5'b01010, 5'b01010, 1'b1, 5'b00010, "worm_tail");
        check_owner(3'd0, "worm_owner_released");
        cycle(5'b01000, 5'b01000, 1'b1, 5'b01000, "worm_next");
    endtask

    task automatic test_credits();
        do_reset("cred_reset");
        for (int k = 0; k < 4; k++) cycle(5'b00001, 5'b00001, 1'b0, 5'b00001, "cred_use");
        cycle(5'b00001, 5'b00001, 1'b0, 5'b00000, "cred_empty_a");
        cycle(5'b00001, 5'b00001, 1'b0, 5'b00000, "cred_empty_b");
        cycle(5'b11111, 5'b11111, 1'b0, 5'b00000, "cred_empty_all");
        cycle(5'b00001, 5'b00001, 1'b1, 5'b00000, "cred_return");
        cycle(5'b00001, 5'b00001, 1'b0, 5'b00001, "cred_one_more");
        cycle(5'b00001, 5'b00001, 1'b0, 5'b00000, "cred_empty_again");
    endtask

    task automatic test_credit_simul();
        cycle(5'b00000, 5'b00000, 1'b1, 5'b00000, "simul_refill");
        cycle(5'b00001, 5'b00001, 1'b1, 5'b00001, "simul_both");
        cycle(5'b00001, 5'b00001, 1'b0, 5'b00001, "simul_still_one");
        cycle(5'b00001, 5'b00001, 1'b0, 5'b00000, "simul_drained");
        check_err(1'b0, "simul_no_err");
    endtask

    task automatic test_credit_err();
        do_reset("err_reset");
        check_err(1'b0, "err_clear");
        cycle(5'b00000, 5'b00000, 1'b1, 5'b00000, "err_overflow");
        check_err(1'b1, "err_set");
        for (int k = 0; k < 3; k++) begin
            cycle(5'b00000, 5'b00000, 1'b0, 5'b00000, "err_idle");
            check_err(1'b1, "err_sticky");
        end
        for (int k = 0; k < 4; k++) cycle(5'b00001, 5'b00001, 1'b0, 5'b00001, "err_cap_use");
        cycle(5'b00001, 5'b00001, 1'b0, 5'b00000, "err_cap_block");
        check_err(1'b1, "err_still_set");
    endtask

    task automatic test_reset_mid();
        do_reset("mid_reset0");
        cycle(5'b00100, 5'b00000, 1'b0, 5'b00100, "mid_flit1");
        cycle(5'b00100, 5'b00000, 1'b0, 5'b00100, "mid_flit2");
        check_owner(3'd2, "mid_owner");
        @(negedge noc_clk);
        noc_rst  = 1'b1;
        in_valid = 5'b00100;
        #1;
        checks++;
        if (in_ready !== '0) begin
            errors++;
            $display("FAIL mid_rst in_ready got=%b exp=0", in_ready);
        end
        @(posedge noc_clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst out_valid got=%b exp=0", out_valid);
        end
        check_owner(3'd0, "mid_rst_owner");
        @(negedge noc_clk);
        noc_rst  = 1'b0;
        in_valid = '0;
        sb.delete();
        last_flit = '0;
        for (int k = 0; k < 4; k++) cycle(5'b10000, 5'b10000, 1'b0, 5'b10000, "mid_after_use");
        cycle(5'b10000, 5'b10000, 1'b0, 5'b00000, "mid_after_block");
    endtask

    initial begin
        test_reset();
        test_rr_alternate();
        test_wormhole();
        test_credits();
        test_credit_simul();
        test_credit_err();
        test_reset();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
